fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage with IF/ID pipeline register for the ARMv8 core. Generates the PC, performs a req/ready fetch from instruction memory, and buffers one instruction through a skid entry when the pipeline stalls. Presents the instruction immediate field and the 2-bit immediate-format select that feed the sign-extend unit. Accepts branch redirects whose offset comes from the sign-extend unit, already shifted left by 2.

## Interface
Parameters
- `RESET_PC`, default 64'h0: first fetch address after reset.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  fetch request; held until `imem_ready`
- `imem_addr`  out  64  fetch address; stable while `imem_req`=1
- `imem_ready`  in  1  response valid this cycle
- `imem_rdata`  in  32  instruction; valid with `imem_ready`
- `stall`  in  1  hazard unit; ID register holds
- `br_taken`  in  1  redirect pulse, one cycle
- `br_pc`  in  64  PC of the branch instruction
- `br_offset`  in  64  sign-extended, <<2 offset from the sign-extend unit
- `id_valid`  out  1  ID register holds a live instruction
- `id_pc`  out  64  PC of the ID instruction
- `id_inst`  out  32  instruction word
- `id_imm`  out  26  `id_inst[25:0]`, to the sign-extend `inst` input
- `id_seu`  out  2  immediate format select, to the sign-extend `seu` input

## Operation
- States: FETCH (request out or about to issue), HOLD (skid full, no request), DRAIN (redirect pending behind an outstanding request).
- Registers: `pc` (next fetch address), `target` (redirect PC), skid entry (pc, inst, valid), ID register.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`:
  - Response is accepted and `pc` increments by 4 (64-bit wrap).
  - If `stall`=0, the response loads the ID register.
  - If `stall`=1, the response goes to the skid entry and the state moves to HOLD.
- HOLD: `imem_req`=0. When `stall`=0, the skid entry loads ID, the skid is cleared, and the state moves to FETCH.
- ID register: loads only when `stall`=0. Load source priority: skid, then accepted response, then bubble (`id_valid`=0).
- Redirect. `br_taken`=1 has priority over `stall` and over any response.
  - Redirect PC = `br_pc` + `br_offset`, modulo 2^64.
  - `id_valid` and the skid are cleared.
  - If FETCH with no `imem_ready` this cycle: `target` is loaded with the redirect PC and the state moves to DRAIN.
  - Otherwise (FETCH with `imem_ready`, or HOLD): `pc` is loaded with the redirect PC and the state moves to FETCH.
- DRAIN: `imem_req`=1 with the old address. The returning response is discarded. On `imem_ready`, `pc`←`target` and the state moves to FETCH. A new `br_taken` in DRAIN overwrites `target`.
- `id_seu` decode, registered with `id_inst`:
  - B (`[31:26]`=000101) → 2'b10
  - CBZ/CBNZ (`[31:24]`=10110100/10110101) → 2'b11
  - LDUR/STUR (`[31:21]`=11111000010/11111000000) → 2'b01
  - all other instructions → 2'b00

## Timing
- Reset values: state FETCH, `pc`=`RESET_PC`, `imem_req`=0 during the reset cycle, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_pc`=0, `id_inst`=0, `id_imm`=0, `id_seu`=2'b00, skid empty.
- First request is issued in the first cycle with `reset`=0.
- With a zero-wait memory (ready the same cycle as the request), throughput is 1 instruction per cycle.
- Fetch-to-ID latency: response accepted at cycle t appears on `id_*` at t+1.
- Redirect penalty: `br_taken` at t gives `imem_addr`=target at t+1, when no request is outstanding.
- `stall` + `imem_ready` with the skid full cannot occur, because HOLD issues no request.
- Reset mid-request abandons the outstanding request. Instruction memory shares `reset` and drops it too.

## Structure
- Package `fetch_pkg`:
  - state enum FETCH/HOLD/DRAIN
  - opcode constants OP_B, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR
  - SEU select constants SEU_I=00, SEU_D=01, SEU_B=10, SEU_CB=11
- Sub-module `inst_class_dec`: combinational, inst[31:21] → 2-bit select. Reused later by the main decoder.

## Test plan
- **Reset and stream.** `RESET_PC`=64'h100, zero-wait memory, `stall`=0. Required: `imem_addr` 100, 104, 108 on consecutive cycles; `id_pc` follows one cycle later; `id_valid`=1 from the second cycle.
- **Stall into skid.** `stall`=1 for 3 cycles while the response for 0x104 returns. Required: ID holds 0x100, the skid holds 0x104, `imem_req`=0. After release: `id_pc`=0x104, then a request for 0x108.
- **Backward branch.** `br_taken` with `br_pc`=0x200 and `br_offset`=64'hFFFF_FFFF_FFFF_FFF0. Required: next `imem_addr`=0x1F0, `id_valid`=0 that cycle.
- **Redirect during wait.** `br_taken` while the request for 0x300 is waiting 2 cycles. Required: DRAIN holds `imem_addr`=0x300, the response is dropped, then target is fetched; `id_valid` stays 0 until the target returns.
- **Decode.** Feed B 0x14000003, CBZ 0xB4000040, LDUR 0xF8408020, ADDI 0x91000421. Required: `id_seu` = 10, 11, 01, 00.
- **Wrap and reset.** `pc`=64'hFFFF_FFFF_FFFF_FFFC gives next fetch 0. Asserting `reset` mid-wait gives all reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [1:0] SEU_I  = 2'b00;
  localparam logic [1:0] SEU_D  = 2'b01;
  localparam logic [1:0] SEU_B  = 2'b10;
  localparam logic [1:0] SEU_CB = 2'b11;

endpackage

// File: rtl/inst_class_dec.sv
// rtl/inst_class_dec.sv - opcode field to sign-extend format select
module inst_class_dec
  import fetch_pkg::*;
(
  input  logic [10:0] i_op,
  output logic [1:0]  o_seu
);

  // Opcode groups are disjoint, so the test order only sets the default
  always_comb begin
    o_seu = SEU_I;
    if (i_op[10:5] == OP_B) begin
      o_seu = SEU_B;
    end else if ((i_op[10:3] == OP_CBZ) || (i_op[10:3] == OP_CBNZ)) begin
      o_seu = SEU_CB;
    end else if ((i_op == OP_LDUR) || (i_op == OP_STUR)) begin
      o_seu = SEU_D;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, req/ready fetch, skid entry and IF/ID register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
)
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_offset,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  output logic [25:0] id_imm,
  output logic [1:0]  id_seu
);

  state_t      r_state;
  state_t      w_next_state;
  logic [63:0] r_pc;
  logic [63:0] r_target;
  logic        r_skid_valid;
  logic [63:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_id_valid;
  logic [63:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic [1:0]  r_id_seu;

  logic [63:0] w_redirect_pc;
  logic        w_accept;
  logic        w_to_target;
  logic        w_load_live;
  logic [63:0] w_src_pc;
  logic [31:0] w_src_inst;
  logic [1:0]  w_src_seu;

  assign w_redirect_pc = br_pc + br_offset;
  // A response is only taken as an instruction in FETCH; DRAIN drops it
  assign w_accept      = (r_state == FETCH) && imem_ready;
  // Redirect while a request is still open must wait for that response
  assign w_to_target   = (r_state != HOLD) && !imem_ready;
  assign w_load_live   = r_skid_valid || w_accept;
  assign w_src_pc      = r_skid_valid ? r_skid_pc   : r_pc;
  assign w_src_inst    = r_skid_valid ? r_skid_inst : imem_rdata;

  inst_class_dec u_dec (
    .i_op  (w_src_inst[31:21]),
    .o_seu (w_src_seu)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic; a redirect overrides stall and any response
  always_comb begin
    w_next_state = r_state;
    if (br_taken) begin
      w_next_state = w_to_target ? DRAIN : FETCH;
    end else begin
      case (r_state)
        FETCH:   if (imem_ready && stall) w_next_state = HOLD;
        HOLD:    if (!stall) w_next_state = FETCH;
        DRAIN:   if (imem_ready) w_next_state = FETCH;
        default: w_next_state = FETCH;
      endcase
    end
  end

  // Request is open in FETCH and DRAIN, never while reset is held
  always_comb begin
    imem_req = 1'b0;
    if (!reset && (r_state != HOLD)) imem_req = 1'b1;
  end

  // Fetch PC and pending redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
    end else if (br_taken) begin
      if (w_to_target) r_target <= w_redirect_pc;
      else             r_pc     <= w_redirect_pc;
    end else if (w_accept) begin
      r_pc <= r_pc + 64'd4;
    end else if ((r_state == DRAIN) && imem_ready) begin
      r_pc <= r_target;
    end
  end

  // Skid entry catches the response that arrives during a stall
  always_ff @(posedge clk) begin
    if (reset || br_taken) begin
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= '0;
    end else if (w_accept && stall) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= r_pc;
      r_skid_inst  <= imem_rdata;
    end else if (!stall) begin
      r_skid_valid <= 1'b0;
    end
  end

  // ID register: skid first, then the accepted response, else a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_seu   <= SEU_I;
    end else if (br_taken) begin
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      r_id_valid <= w_load_live;
      if (w_load_live) begin
        r_id_pc   <= w_src_pc;
        r_id_inst <= w_src_inst;
        r_id_seu  <= w_src_seu;
      end
    end
  end

  assign imem_addr = r_pc;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_inst   = r_id_inst;
  assign id_imm    = r_id_inst[25:0];
  assign id_seu    = r_id_seu;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench: directed literals plus random run against a queue model
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_pc = '0;
  logic [63:0] br_offset = '0;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic [25:0] id_imm;
  logic [1:0]  id_seu;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_imm     (id_imm),
    .id_seu     (id_seu)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] memtab [64];
  int          wait_sel = 0;
  int          mem_wait = -1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } slot_t;

  logic [63:0] m_pc = RST_PC;
  logic [63:0] m_target = RST_PC;
  bit          m_discard = 1'b0;
  bit          m_known = 1'b0;
  slot_t       m_skid [$];
  bit          m_id_valid = 1'b0;
  slot_t       m_id = '0;

  logic        s_req;
  logic        s_id_valid;
  logic [63:0] s_addr;
  logic [63:0] s_id_pc;
  logic [31:0] s_id_inst;
  logic [25:0] s_imm;
  logic [1:0]  s_seu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] seu_of(input logic [31:0] w);
    casez (w)
      32'b000101??_????????_????????_????????: return 2'b10;
      32'b1011010?_????????_????????_????????: return 2'b11;
      32'b11111000_0?0?????_????????_????????: return 2'b01;
      default:                                 return 2'b00;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit br,
                            input logic [63:0] redir, input bit rdy, input logic [31:0] rd);
    slot_t f;
    bit    rq;
    bit    acc;
    if (rst) begin
      m_pc       = RST_PC;
      m_target   = RST_PC;
      m_discard  = 1'b0;
      m_skid.delete();
      m_id_valid = 1'b0;
      m_id       = '0;
      m_known    = 1'b1;
    end else begin
      rq     = (m_skid.size() == 0);
      acc    = rq && rdy && !m_discard;
      f.pc   = m_pc;
      f.inst = rd;
      if (br) begin
        m_id_valid = 1'b0;
        m_skid.delete();
        if (rq && !rdy) begin
          m_discard = 1'b1;
          m_target  = redir;
        end else begin
          m_pc      = redir;
          m_discard = 1'b0;
        end
      end else begin
        if (m_discard) begin
          if (rdy) begin
            m_pc      = m_target;
            m_discard = 1'b0;
          end
        end else if (acc) begin
          m_pc = m_pc + 64'd4;
        end
        if (!st) begin
          if (m_skid.size() != 0) begin
            m_id       = m_skid.pop_front();
            m_id_valid = 1'b1;
          end else if (acc) begin
            m_id       = f;
            m_id_valid = 1'b1;
          end else begin
            m_id_valid = 1'b0;
          end
        end else if (acc) begin
          m_skid.push_back(f);
        end
      end
    end
  endtask

  task automatic tick(input bit rst, input bit st, input bit br,
                      input logic [63:0] bp, input logic [63:0] bo);
    bit rq;
    @(negedge clk);
    reset     = rst;
    stall     = st;
    br_taken  = br;
    br_pc     = bp;
    br_offset = bo;
    #1;
    s_req      = imem_req;
    s_addr     = imem_addr;
    s_id_valid = id_valid;
    s_id_pc    = id_pc;
    s_id_inst  = id_inst;
    s_imm      = id_imm;
    s_seu      = id_seu;
    if (m_known) begin
      rq = !rst && (m_skid.size() == 0);
      chk("imem_req", 64'(s_req), 64'(rq));
      if (rq) chk("imem_addr", s_addr, m_pc);
      chk("id_valid", 64'(s_id_valid), 64'(m_id_valid));
      if (m_id_valid) begin
        chk("id_pc", s_id_pc, m_id.pc);
        chk("id_inst", 64'(s_id_inst), 64'(m_id.inst));
        chk("id_imm", 64'(s_imm), 64'(m_id.inst[25:0]));
        chk("id_seu", 64'(s_seu), 64'(seu_of(m_id.inst)));
      end
    end
    if (imem_req === 1'b1) begin
      if (mem_wait < 0) mem_wait = (wait_sel < 0) ? int'($urandom_range(0, 2)) : wait_sel;
    end else begin
      mem_wait = -1;
    end
    imem_ready = (imem_req === 1'b1) && (mem_wait == 0);
    imem_rdata = imem_ready ? memtab[imem_addr[7:2]] : 32'hDEAD_BEEF;
    @(posedge clk);
    if (rst || imem_ready) mem_wait = -1;
    else if (mem_wait > 0) mem_wait--;
    model_step(rst, st, br, bp + bo, imem_ready, imem_rdata);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bit          r_rst;
    bit          r_st;
    bit          r_br;
    int          off;
    logic [63:0] bp;
    logic [63:0] bo;

    for (int i = 0; i < 64; i++) memtab[i] = $urandom();
    memtab[0] = 32'h14000003;
    memtab[1] = 32'hB4000040;
    memtab[2] = 32'hF8408020;
    memtab[3] = 32'h91000421;

    // reset and zero-wait stream from 0x100
    wait_sel = 0;
    do_reset();
    chk("rst_req", 64'(s_req), 64'd0);
    chk("rst_addr", s_addr, 64'h100);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("first_req", 64'(s_req), 64'd1);
    chk("stream_addr0", s_addr, 64'h100);
    chk("rst_id_valid", 64'(s_id_valid), 64'd0);
    chk("rst_id_pc", s_id_pc, 64'd0);
    chk("rst_id_inst", 64'(s_id_inst), 64'd0);
    chk("rst_id_seu", 64'(s_seu), 64'd0);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("stream_addr1", s_addr, 64'h104);
    chk("stream_valid1", 64'(s_id_valid), 64'd1);
    chk("stream_id_pc1", s_id_pc, 64'h100);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("stream_addr2", s_addr, 64'h108);
    chk("stream_id_pc2", s_id_pc, 64'h104);

    // stall into the skid while 0x104 returns
    do_reset();
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    chk("skid_resp_addr", s_addr, 64'h104);
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    chk("hold_req", 64'(s_req), 64'd0);
    chk("hold_id_pc", s_id_pc, 64'h100);
    chk("hold_id_valid", 64'(s_id_valid), 64'd1);
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("release_req", 64'(s_req), 64'd0);

    // backward branch issued in the cycle after release
    tick(1'b0, 1'b0, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("skid_out_pc", s_id_pc, 64'h104);
    chk("after_hold_addr", s_addr, 64'h108);
    chk("after_hold_req", 64'(s_req), 64'd1);
    tick(1'b0, 1'b0, 1'b1, 64'h300, 64'h0);
    chk("bwd_br_addr", s_addr, 64'h1F0);
    chk("bwd_br_valid", 64'(s_id_valid), 64'd0);

    // redirect while the request for 0x300 waits two cycles
    wait_sel = 2;
    tick(1'b0, 1'b0, 1'b1, 64'h500, 64'h0);
    chk("wait_addr", s_addr, 64'h300);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("drain_addr1", s_addr, 64'h300);
    chk("drain_req1", 64'(s_req), 64'd1);
    chk("drain_valid1", 64'(s_id_valid), 64'd0);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("drain_addr2", s_addr, 64'h300);
    chk("drain_valid2", 64'(s_id_valid), 64'd0);
    wait_sel = 0;
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("target_addr", s_addr, 64'h500);
    chk("target_valid0", 64'(s_id_valid), 64'd0);
    tick(1'b0, 1'b0, 1'b1, 64'h400, 64'h0);
    chk("target_valid1", 64'(s_id_valid), 64'd1);
    chk("target_id_pc", s_id_pc, 64'h500);

    // decode of B, CBZ, LDUR, ADDI fetched from 0x400
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("dec_addr", s_addr, 64'h400);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("dec_b_seu", 64'(s_seu), 64'd2);
    chk("dec_b_imm", 64'(s_imm), 64'd3);
    chk("dec_b_inst", 64'(s_id_inst), 64'h14000003);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("dec_cbz_seu", 64'(s_seu), 64'd3);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("dec_ldur_seu", 64'(s_seu), 64'd1);
    tick(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    chk("dec_addi_seu", 64'(s_seu), 64'd0);

    // 64-bit wrap, then reset mid-wait
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("wrap_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_sel = 2;
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("wrap_zero", s_addr, 64'h0);
    chk("wrap_req", 64'(s_req), 64'd1);
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    chk("midrst_req", 64'(s_req), 64'd0);
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    chk("midrst_addr", s_addr, RST_PC);
    chk("midrst_valid", 64'(s_id_valid), 64'd0);
    chk("midrst_id_pc", s_id_pc, 64'd0);
    chk("midrst_inst", 64'(s_id_inst), 64'd0);
    chk("midrst_seu", 64'(s_seu), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 4))
        0:       memtab[i] = {6'b000101, 26'($urandom())};
        1:       memtab[i] = {7'b1011010, 25'($urandom())};
        2:       memtab[i] = {8'b11111000, 1'b0, 1'($urandom()), 1'b0, 21'($urandom())};
        default: memtab[i] = $urandom();
      endcase
    end
    wait_sel = -1;
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 9) < 3);
      r_br  = ($urandom_range(0, 11) == 0);
      bp    = {$urandom(), $urandom()};
      off   = int'($urandom_range(0, 4095)) - 2048;
      bo    = 64'(off) << 2;
      tick(r_rst, r_st, r_br, bp, bo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
